// File: rtl/serial_pkg.sv
// Shared types and line-level constants for the serial frame transmitter.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Counts CLKS_PER_BIT cycles while enabled and pulses bit_tick on the last
// cycle of each bit period.
module bit_timer
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic bit_tick
);

  localparam int            CW   = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_tick = enable && (cnt == LAST);

  // NOTE: sequential state is always updated with <= so every flop samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= bit_tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-in serial-out frame transmitter: start bit, WIDTH payload bits,
// stop bit, each held CLKS_PER_BIT cycles, with a valid/ready input.
module serial_frame_tx
  import serial_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int LSB_FIRST    = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             dout_n,
  output logic             busy,
  output logic             done
);

  localparam int            BW       = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic             done_q;
  logic             bit_tick;
  logic             handshake;
  logic             data_bit;

  assign handshake = din_valid && din_ready;
  assign data_bit  = (LSB_FIRST != 0) ? shreg[0] : shreg[WIDTH-1];

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (handshake),
    .enable  (state != IDLE),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: the payload register is reset too, so an aborted frame leaves no
  // stale data behind for the next one.
  always_ff @(posedge clock) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == STOP) && bit_tick;
      if (handshake) begin
        shreg   <= din;
        bit_cnt <= '0;
      end else if ((state == DATA) && bit_tick) begin
        shreg   <= (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);
        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
      end
    end
  end

  // NOTE: every output of this block gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    din_ready  = 1'b0;
    busy       = 1'b1;
    dout       = LINE_IDLE;
    case (state)
      IDLE: begin
        din_ready = 1'b1;
        busy      = 1'b0;
        if (din_valid) state_next = START;
      end
      START: begin
        dout = START_BIT;
        if (bit_tick) state_next = DATA;
      end
      DATA: begin
        dout = data_bit;
        if (bit_tick && (bit_cnt == LAST_BIT)) state_next = STOP;
      end
      STOP: begin
        dout = STOP_BIT;
        if (bit_tick) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // The reset cycle itself presents an idle, non-accepting line.
    if (reset) begin
      din_ready = 1'b0;
      busy      = 1'b0;
      dout      = LINE_IDLE;
    end
  end

  assign dout_n = ~dout;
  assign done   = done_q && !reset;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench: three transmitter configurations, payloads queued on
// handshake and compared bit by bit as each frame appears on the line.
module tb_serial_frame_tx;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_in    [NI];
  logic [7:0] din         [NI];
  logic       din_valid   [NI];
  logic       din_ready_w [NI];
  logic       dout_w      [NI];
  logic       dout_n_w    [NI];
  logic       busy_w      [NI];
  logic       done_w      [NI];

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] sb_q0[$];
  logic [7:0] sb_q1[$];
  logic [7:0] sb_q2[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp_v);
    end
  endtask

  task automatic sb_push(input int g, input logic [7:0] v);
    case (g)
      0:       sb_q0.push_back(v);
      1:       sb_q1.push_back(v);
      default: sb_q2.push_back(v);
    endcase
  endtask

  function automatic bit sb_pop(input int g, output logic [7:0] v);
    v = '0;
    case (g)
      0:       if (sb_q0.size() > 0) begin v = sb_q0.pop_front(); return 1'b1; end
      1:       if (sb_q1.size() > 0) begin v = sb_q1.pop_front(); return 1'b1; end
      default: if (sb_q2.size() > 0) begin v = sb_q2.pop_front(); return 1'b1; end
    endcase
    return 1'b0;
  endfunction

  function automatic int sb_size(input int g);
    case (g)
      0:       return sb_q0.size();
      1:       return sb_q1.size();
      default: return sb_q2.size();
    endcase
  endfunction

  // Line bit k of a frame: start, eight payload bits, stop.
  function automatic logic exp_bit(input logic [7:0] p, input int lsb, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return (lsb != 0) ? p[k-1] : p[8-k];
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int CPB = (g == 2) ? 1 : 4;
    localparam int LSB = (g == 1) ? 0 : 1;

    serial_frame_tx #(
      .WIDTH       (8),
      .CLKS_PER_BIT(CPB),
      .LSB_FIRST   (LSB)
    ) dut (
      .clock    (clk),
      .reset    (reset_in[g]),
      .din      (din[g]),
      .din_valid(din_valid[g]),
      .din_ready(din_ready_w[g]),
      .dout     (dout_w[g]),
      .dout_n   (dout_n_w[g]),
      .busy     (busy_w[g]),
      .done     (done_w[g])
    );

    initial begin : mon
      logic [7:0] p;
      logic [9:0] obs;
      logic [9:0] exp_v;
      bit         have, stable, inv_ok, quiet_ok, aborted;
      forever begin
        @(negedge clk);
        if (busy_w[g] === 1'b1) begin
          have = sb_pop(g, p);
          if (!have) check($sformatf("frame_expected[%0d]", g), 0, 1);
          obs      = '0;
          stable   = 1'b1;
          inv_ok   = 1'b1;
          quiet_ok = 1'b1;
          aborted  = 1'b0;
          for (int n = 0; n < 10 * CPB && !aborted; n++) begin
            if (n > 0) @(negedge clk);
            if (reset_in[g]) begin
              aborted = 1'b1;
            end else begin
              if (n % CPB == 0) obs[n / CPB] = dout_w[g];
              else if (dout_w[g] !== obs[n / CPB]) stable = 1'b0;
              if (dout_n_w[g] !== ~dout_w[g]) inv_ok = 1'b0;
              if (busy_w[g] !== 1'b1 || din_ready_w[g] !== 1'b0 || done_w[g] !== 1'b0)
                quiet_ok = 1'b0;
            end
          end
          if (aborted) begin
            @(negedge clk);
            check($sformatf("abort_line_busy_done[%0d]", g),
                  {dout_w[g], busy_w[g], done_w[g]}, 3'b100);
            @(negedge clk);
            check($sformatf("abort_no_done[%0d]", g), done_w[g], 1'b0);
          end else begin
            for (int k = 0; k < 10; k++) exp_v[k] = exp_bit(p, LSB, k);
            check($sformatf("frame_bits[%0d] p=%0h", g, p), obs, exp_v);
            check($sformatf("bit_hold[%0d]", g), stable, 1'b1);
            check($sformatf("dout_n_inverse[%0d]", g), inv_ok, 1'b1);
            check($sformatf("busy_ready_done_in_frame[%0d]", g), quiet_ok, 1'b1);
            @(negedge clk);
            check($sformatf("end_busy_done_ready[%0d]", g),
                  {busy_w[g], done_w[g], din_ready_w[g]}, 3'b011);
          end
        end
      end
    end
  end

  task automatic send(input int g, input logic [7:0] d, input bit hold);
    int n = 0;
    @(negedge clk);
    din[g]       = d;
    din_valid[g] = 1'b1;
    while (din_ready_w[g] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("hs_ready[%0d]", g), din_ready_w[g], 1'b1);
    sb_push(g, d);
    @(posedge clk);
    #1;
    if (!hold) din_valid[g] = 1'b0;
    @(negedge clk);
    check($sformatf("start_latency[%0d]", g), {busy_w[g], dout_w[g]}, 2'b10);
  endtask

  // First payload accepted, second held on din with din_valid never dropped.
  task automatic back_to_back(input int g, input logic [7:0] a, input logic [7:0] b,
                              input int gap_exp);
    int n = 1;
    send(g, a, 1'b1);
    din[g] = b;
    while (din_ready_w[g] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("b2b_gap[%0d]", g), n, gap_exp);
    sb_push(g, b);
    @(posedge clk);
    #1;
    din_valid[g] = 1'b0;
    @(negedge clk);
    check($sformatf("b2b_single_ready[%0d]", g),
          {din_ready_w[g], busy_w[g], dout_w[g]}, 3'b010);
  endtask

  task automatic wait_idle(input int g);
    int n = 0;
    @(negedge clk);
    while (busy_w[g] !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("idle_timeout[%0d]", g), busy_w[g], 1'b0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      reset_in[i]  = 1'b1;
      din[i]       = '0;
      din_valid[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++)
      check($sformatf("reset_outputs[%0d]", i),
            {din_ready_w[i], dout_w[i], dout_n_w[i], busy_w[i], done_w[i]}, 5'b01000);
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) reset_in[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++)
      check($sformatf("post_reset_ready[%0d]", i), {din_ready_w[i], busy_w[i]}, 2'b10);

    // Basic frame, then back-to-back with din_valid held high.
    send(0, 8'hA5, 1'b0);
    wait_idle(0);
    back_to_back(0, 8'h00, 8'hFF, 41);
    wait_idle(0);

    // din and din_valid scrambled while the frame is on the line.
    send(0, 8'hC3, 1'b0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      din[0]       = 8'($urandom);
      din_valid[0] = 1'($urandom_range(0, 1));
    end
    din_valid[0] = 1'b0;
    wait_idle(0);

    // Reset in cycle 13 of a frame, then a clean frame afterwards.
    send(0, 8'h5A, 1'b0);
    repeat (11) @(negedge clk);
    @(posedge clk);
    #1;
    reset_in[0] = 1'b1;
    @(posedge clk);
    #1;
    reset_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    send(0, 8'h3C, 1'b0);
    wait_idle(0);

    // Reset and din_valid together: reset wins, nothing is accepted.
    @(negedge clk);
    reset_in[0]  = 1'b1;
    din[0]       = 8'h77;
    din_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    reset_in[0]  = 1'b0;
    din_valid[0] = 1'b0;
    @(negedge clk);
    check("reset_beats_valid", {busy_w[0], din_ready_w[0]}, 2'b01);
    repeat (3) @(negedge clk);
    check("reset_beats_valid_later", busy_w[0], 1'b0);

    // MSB-first configuration.
    send(1, 8'hA5, 1'b0);
    wait_idle(1);
    send(1, 8'h81, 1'b0);
    wait_idle(1);

    // One clock per bit.
    send(2, 8'h3C, 1'b0);
    wait_idle(2);
    back_to_back(2, 8'h01, 8'h80, 11);
    wait_idle(2);

    repeat (4) @(negedge clk);
    for (int i = 0; i < NI; i++)
      check($sformatf("scoreboard_drained[%0d]", i), sb_size(i), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8: number of payload bits per frame (legal range 1..32).
REQ-002 The module SHALL have parameter CLKS_PER_BIT, default 4: clock cycles each serial bit is held (legal range 1..65535).
REQ-003 The module SHALL have parameter LSB_FIRST, default 1: 1 sends bit 0 first, 0 sends bit WIDTH-1 first.
REQ-004 Port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port din, input, WIDTH bits: parallel payload, sampled only on an accepted handshake.
REQ-007 Port din_valid, input, 1 bit: din holds a payload to send.
REQ-008 Port din_ready, output, 1 bit: transmitter can accept a payload this cycle.
REQ-009 Port dout, output, 1 bit: serial line, idle level 1.
REQ-010 Port dout_n, output, 1 bit: always the inverse of dout.
REQ-011 Port busy, output, 1 bit: a frame is in progress.
REQ-012 Port done, output, 1 bit: one-cycle pulse marking frame completion.

Function
REQ-013 The module SHALL implement FSM states IDLE, START, DATA and STOP.
REQ-014 The frame SHALL consist of 1 start bit (0), then WIDTH payload bits in LSB_FIRST order, then 1 stop bit (1); each bit SHALL be held for exactly CLKS_PER_BIT cycles.
REQ-015 In IDLE: din_ready=1, busy=0, dout=1; in all other states: din_ready=0, busy=1.
REQ-016 A handshake SHALL occur on a rising edge where din_valid=1 and din_ready=1; at that edge din SHALL be latched into a shift register and the FSM SHALL move to START.
REQ-017 dout SHALL go to 0 in the first cycle after the handshake edge (latency 1 cycle).
REQ-018 A frame SHALL occupy exactly (WIDTH+2)*CLKS_PER_BIT cycles, counted from the cycle after the handshake.
REQ-019 START SHALL transition to DATA after CLKS_PER_BIT cycles.
REQ-020 DATA SHALL transition to STOP after WIDTH bit periods; a bit counter SHALL track bits sent, reaching WIDTH-1 on the last payload bit.
REQ-021 STOP SHALL transition to IDLE after CLKS_PER_BIT cycles.
REQ-022 done SHALL be 1 for exactly the first cycle back in IDLE after a completed frame, and 0 otherwise.
REQ-023 Minimum spacing between frames SHALL be one IDLE cycle; a din_valid held high continuously SHALL be accepted in that first IDLE cycle.
REQ-024 Changes on din or din_valid while busy=1 SHALL have no effect on the frame in progress.
REQ-025 With CLKS_PER_BIT=1, each bit SHALL last one cycle with no extra gaps.
REQ-026 The bit-period counter SHALL be clog2(CLKS_PER_BIT) bits wide, minimum 1; it SHALL wrap to 0 at CLKS_PER_BIT-1.

Reset
REQ-027 Reset SHALL force state=IDLE, dout=1, dout_n=0, busy=0, done=0, din_ready=0 (in the reset cycle only), and clear all counters and the shift register.
REQ-028 Reset asserted mid-frame SHALL abort the frame; dout SHALL be 1 in the next cycle; no done pulse SHALL follow.
REQ-029 When reset and din_valid are asserted in the same cycle, reset SHALL win; no payload is accepted.

Structure
REQ-030 Package serial_pkg SHALL hold the state enum (IDLE/START/DATA/STOP) and the constants LINE_IDLE=1, START_BIT=0, STOP_BIT=1.
REQ-031 Sub-module bit_timer SHALL count CLKS_PER_BIT cycles and emit a one-cycle bit_tick; it SHALL be cleared on reset and on handshake.
REQ-032 The FSM, shift register and bit counter SHALL reside in serial_frame_tx.

Verification (WIDTH=8, CLKS_PER_BIT=4, LSB_FIRST=1 unless noted)
REQ-033 Send din=8'hA5 -> dout sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles total); done pulses at cycle 41; dout_n is always ~dout.
REQ-034 Set LSB_FIRST=0 and send 8'hA5 -> payload bits on dout are 1,0,1,0,0,1,0,1.
REQ-035 Hold din_valid=1 and send 8'h00 then 8'hFF back-to-back -> second frame starts exactly 1 IDLE cycle after the first stop bit; din_ready=1 for 1 cycle between frames.
REQ-036 Assert reset in cycle 13 of a frame -> dout=1, busy=0 next cycle; no done pulse; the next frame is sent correctly.
REQ-037 Set CLKS_PER_BIT=1 and send 8'h3C -> frame takes 10 cycles, dout=0,0,0,1,1,1,1,0,0,1.
REQ-038 Toggle din while busy=1 -> the transmitted payload is unchanged.
